// File: rtl/stream_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo_if
//  Description : Producer/consumer handshake bundle for stream_fifo.
//                slave  = FIFO side, master = the agent driving strobes/data.
//  Revision    : 1.0  initial release
// ============================================================================
interface stream_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [WIDTH-1:0]    in_data;
  logic                in_strobe;
  logic [WIDTH-1:0]    out_data;
  logic                out_strobe;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic [ADDR_WIDTH:0] count;
  logic                overflow;
  logic                underflow;

  modport slave (
    input  in_data, in_strobe, out_strobe,
    output out_data, full, empty, almost_full, count, overflow, underflow
  );

  modport master (
    output in_data, in_strobe, out_strobe,
    input  out_data, full, empty, almost_full, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo
//  Description : Multi-entry first-word fall-through FIFO with occupancy
//                count, almost-full threshold, sticky error flags and a
//                synchronous flush.
//  Revision    : 1.0  initial release
// ============================================================================
module stream_fifo #(
  parameter int WIDTH             = 8,
  parameter int ADDR_WIDTH        = 4,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  wire logic      clk,
  input  wire logic      reset,
  input  wire logic      flush,
  stream_fifo_if.slave   bus
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0] CNT_FULL  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LEVEL  = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  almost_full_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  do_wr;
  logic                  do_rd;

  // Accept decisions use the registered flags; flush cancels both sides.
  assign do_wr = bus.in_strobe  && !full_q  && !flush;
  assign do_rd = bus.out_strobe && !empty_q && !flush;

  // Next occupancy: simultaneous accepted read and write cancel out.
  always_comb begin
    cnt_nxt = cnt;
    if (flush) begin
      cnt_nxt = '0;
    end else if (do_wr && !do_rd) begin
      cnt_nxt = cnt + CNT_ONE;
    end else if (do_rd && !do_wr) begin
      cnt_nxt = cnt - CNT_ONE;
    end
  end

  // Storage is never reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers, occupancy, status flags derived from next count, sticky errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (do_wr) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (do_rd) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (bus.in_strobe && full_q) begin
          overflow_q <= 1'b1;
        end
        if (bus.out_strobe && empty_q) begin
          underflow_q <= 1'b1;
        end
      end
      cnt           <= cnt_nxt;
      full_q        <= (cnt_nxt == CNT_FULL);
      empty_q       <= (cnt_nxt == '0);
      almost_full_q <= (cnt_nxt >= AF_LEVEL);
    end
  end

  // Head word falls through combinationally; forced to zero when empty.
  assign bus.out_data    = empty_q ? '0 : mem[rd_ptr];
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almost_full = almost_full_q;
  assign bus.count       = cnt;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_fifo
//  Description : Self-checking bench for stream_fifo: queue-based reference
//                model checked every cycle plus directed literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stream_fifo;

  localparam int WIDTH  = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = 12;

  logic clk;
  logic reset;
  logic flush;

  int compared;
  int mismatched;

  stream_fifo_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  stream_fifo #(
    .WIDTH(WIDTH),
    .ADDR_WIDTH(AW),
    .ALMOST_FULL_LEVEL(AF_LVL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue plus two sticky bits.
  logic [WIDTH-1:0] mq[$];
  bit m_ovf;
  bit m_unf;
  bit m_was_full;
  bit m_was_empty;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_was_full  = (mq.size() == DEPTH);
      m_was_empty = (mq.size() == 0);
      if (bus.out_strobe) begin
        if (m_was_empty) m_unf = 1'b1;
        else void'(mq.pop_front());
      end
      if (bus.in_strobe) begin
        if (m_was_full) m_ovf = 1'b1;
        else mq.push_back(bus.in_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_count",  32'(bus.count),       32'(mq.size()));
    check("m_empty",  32'(bus.empty),       32'(mq.size() == 0));
    check("m_full",   32'(bus.full),        32'(mq.size() == DEPTH));
    check("m_afull",  32'(bus.almost_full), 32'(mq.size() >= AF_LVL));
    check("m_ovf",    32'(bus.overflow),    32'(m_ovf));
    check("m_unf",    32'(bus.underflow),   32'(m_unf));
    check("m_data",   32'(bus.out_data),    (mq.size() == 0) ? 32'h0 : 32'(mq[0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_data    = '0;
    bus.in_strobe  = 1'b0;
    bus.out_strobe = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();

    // Idle after reset.
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_data",  32'(bus.out_data), 32'd0);
    check("rst_ovf",   32'(bus.overflow), 32'd0);
    check("rst_unf",   32'(bus.underflow), 32'd0);

    // Fill with 0x01..0x10; almost_full must rise exactly at count 12.
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_strobe = 1'b1;
      bus.in_data   = 8'(i + 1);
      tick();
      if (i == 10) check("af_at11", 32'(bus.almost_full), 32'd0);
      if (i == 11) check("af_at12", 32'(bus.almost_full), 32'd1);
      if (i == 14) check("full_at15", 32'(bus.full), 32'd0);
    end
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_head",  32'(bus.out_data), 32'h01);
    bus.in_data = 8'hFF;
    tick();
    bus.in_strobe = 1'b0;
    check("ovf_set",   32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_head",  32'(bus.out_data), 32'h01);

    // Both strobes while full: read wins, write rejected.
    bus.in_strobe  = 1'b1;
    bus.out_strobe = 1'b1;
    bus.in_data    = 8'h77;
    tick();
    bus.in_strobe  = 1'b0;
    bus.out_strobe = 1'b0;
    check("fs_count", 32'(bus.count), 32'd15);
    check("fs_full",  32'(bus.full),  32'd0);
    check("fs_ovf",   32'(bus.overflow), 32'd1);
    check("fs_head",  32'(bus.out_data), 32'h02);

    // Drain the remaining 15 in order.
    for (int i = 2; i <= DEPTH; i++) begin
      check("drain_data", 32'(bus.out_data), 32'(i));
      bus.out_strobe = 1'b1;
      tick();
    end
    bus.out_strobe = 1'b0;
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_data0", 32'(bus.out_data), 32'd0);

    // Underflow, then simultaneous strobes while empty.
    bus.out_strobe = 1'b1;
    tick();
    bus.out_strobe = 1'b0;
    check("unf_set",   32'(bus.underflow), 32'd1);
    check("unf_count", 32'(bus.count), 32'd0);
    bus.in_strobe  = 1'b1;
    bus.out_strobe = 1'b1;
    bus.in_data    = 8'hA5;
    tick();
    bus.in_strobe  = 1'b0;
    bus.out_strobe = 1'b0;
    check("es_count", 32'(bus.count), 32'd1);
    check("es_data",  32'(bus.out_data), 32'hA5);
    bus.out_strobe = 1'b1;
    tick();
    bus.out_strobe = 1'b0;
    check("es_drain", 32'(bus.empty), 32'd1);

    // Sustained streaming at occupancy 3 across two pointer wraps.
    for (int i = 0; i < 3; i++) begin
      bus.in_strobe = 1'b1;
      bus.in_data   = 8'(8'h80 + i);
      tick();
    end
    for (int j = 0; j < 40; j++) begin
      check("st_head", 32'(bus.out_data), 32'(8'h80 + j));
      bus.in_strobe  = 1'b1;
      bus.out_strobe = 1'b1;
      bus.in_data    = 8'(8'h83 + j);
      tick();
      check("st_count", 32'(bus.count), 32'd3);
    end
    bus.in_strobe = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("st_tail", 32'(bus.out_data), 32'(8'h80 + 40 + k));
      tick();
    end
    bus.out_strobe = 1'b0;
    check("st_empty", 32'(bus.empty), 32'd1);

    // Flush overrides a same-cycle write and clears the sticky flags.
    for (int i = 0; i < 7; i++) begin
      bus.in_strobe = 1'b1;
      bus.in_data   = 8'(8'h40 + i);
      tick();
    end
    check("pre_flush_count", 32'(bus.count), 32'd7);
    flush         = 1'b1;
    bus.in_data   = 8'hEE;
    tick();
    flush         = 1'b0;
    bus.in_strobe = 1'b0;
    check("fl_count", 32'(bus.count), 32'd0);
    check("fl_empty", 32'(bus.empty), 32'd1);
    check("fl_ovf",   32'(bus.overflow), 32'd0);
    check("fl_unf",   32'(bus.underflow), 32'd0);
    check("fl_data",  32'(bus.out_data), 32'd0);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) begin
      bus.in_strobe = 1'b1;
      bus.in_data   = 8'(8'h20 + i);
      tick();
    end
    check("pre_rst_count", 32'(bus.count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("ar_count", 32'(bus.count), 32'd0);
    check("ar_empty", 32'(bus.empty), 32'd1);
    check("ar_data",  32'(bus.out_data), 32'd0);
    tick();
    reset       = 1'b0;
    bus.in_data = 8'h3C;
    tick();
    bus.in_strobe = 1'b0;
    check("post_rst_count", 32'(bus.count), 32'd1);
    check("post_rst_data",  32'(bus.out_data), 32'h3C);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised multi-entry synchronous FIFO: the deeper, higher-throughput successor to the one-level buffer.
- Sits between byte producers (USB/SPI receive paths) and consumers (serializers, controller emulation engines).
- Uses level-sensitive strobes, so each side can move one word per clock.
- Adds occupancy count, almost-full threshold, sticky overflow/underflow error flags and a synchronous flush.

Parameters:
WIDTH, 8, data word width in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16 entries)
ALMOST_FULL_LEVEL, 12, count at or above which almost_full asserts; legal range 1..DEPTH

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous empty-and-clear, one cycle wide
in_data  input  WIDTH  write data
in_strobe  input  1  level: write in_data this cycle
out_data  output  WIDTH  head-of-queue word (first-word fall-through)
out_strobe  input  1  level: pop head word this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= ALMOST_FULL_LEVEL
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (async, any time, including mid-burst): pointers=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, out_data=0. Storage contents are not cleared and are don't-care.
- Storage: DEPTH x WIDTH register array; write pointer and read pointer are ADDR_WIDTH bits each and wrap modulo DEPTH with no special case.
- Write accept: in_strobe && !full, using registered full. Word stored at wr_ptr; wr_ptr+1.
- Read accept: out_strobe && !empty. rd_ptr+1.
- count update, all registered:
  - write only: +1
  - read only: -1
  - both or neither: unchanged
- full, empty and almost_full are registered and derived from next-state count, so they are valid in the same cycle as count.
- Simultaneous strobes when full: read accepted, write rejected (overflow set). Count drops to DEPTH-1.
- Simultaneous strobes when empty: write accepted, read rejected (underflow set). Count becomes 1.
- Latency: a word written on cycle N appears on out_data on cycle N+1 with empty=0. No extra pipeline stage.
- out_data = mem[rd_ptr] when !empty, else 0. After a pop, the next word is presented on the following cycle.
- Error flags:
  - overflow <= 1 on rejected write (in_strobe && full)
  - underflow <= 1 on rejected read (out_strobe && empty)
  - cleared only by reset or flush
  - a rejected write does not disturb storage or pointers
- flush: next cycle pointers=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0. flush overrides same-cycle strobes: the write is discarded, the read is a no-op, and neither sets an error flag.
- Throughput: sustained one write plus one read per clock at any occupancy 1..DEPTH-1.
- count width ADDR_WIDTH+1 so DEPTH is representable; no other arithmetic saturation.

Test Plan:
- Reset then idle 5 cycles -> empty=1, full=0, count=0, out_data=0, overflow=underflow=0.
- Write 0x01..0x10 on 16 consecutive cycles, then one more write of 0xFF.
  - Required: almost_full rises the cycle count reaches 12; full=1 at count 16; overflow=1 after the 0xFF write.
  - Popping 16 returns 0x01..0x10 in order, then empty=1, with 0xFF never seen.
- With FIFO full, assert in_strobe and out_strobe together for one cycle -> count=15, full=0, overflow=1, head advances by one.
- With FIFO empty, pulse out_strobe -> underflow=1, count stays 0. Then simultaneous write 0xA5 and read -> count=1, out_data=0xA5.
- Stream 40 words with both strobes high continuously at occupancy 3 -> all words emerge in order (pointers wrap twice), count stays 3.
- Fill 7 words, assert flush together with in_strobe -> next cycle count=0, empty=1, flags clear.
  - Then assert reset asynchronously mid-write burst -> all outputs return to reset values immediately.
  - First write after reset releases appears on out_data one cycle later.
